// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: frame sequencer for the UART receiver (start / data / parity / stop).
// Build option RX_FSM_FRAME_ERR_EN adds the sticky frm_err flag; otherwise frm_err is tied low.
module uart_rx_fsm #(
    parameter int PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [5:0] edge_cnt,
    input  logic [3:0] bit_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       cnt_en,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       frm_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [5:0] EDGE_LAST = 6'(PRESCALE);
    localparam logic [5:0] EDGE_CHK  = 6'(PRESCALE - 1);
    localparam logic [3:0] DATA_BITS = 4'd8;

    state_t state, state_nxt;
    logic   par_en_q, par_en_nxt;
    logic   data_valid_nxt;
    logic   edge_last, edge_chk;

    assign edge_last = (edge_cnt == EDGE_LAST);
    assign edge_chk  = (edge_cnt == EDGE_CHK);

    // NOTE: state elements use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            par_en_q   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            par_en_q   <= par_en_nxt;
            data_valid <= data_valid_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt      = state;
        par_en_nxt     = par_en_q;
        data_valid_nxt = 1'b0;
        cnt_en         = 1'b0;
        dat_samp_en    = 1'b0;
        deser_en       = 1'b0;
        strt_chk_en    = 1'b0;
        par_chk_en     = 1'b0;
        stp_chk_en     = 1'b0;

        case (state)
            IDLE: begin
                if (!rx_in) begin
                    state_nxt  = START;
                    par_en_nxt = par_en;
                end
            end
            START: begin
                cnt_en      = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = edge_chk;
                if (edge_last) begin
                    state_nxt = strt_glitch ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_en      = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = edge_chk;
                if (edge_last && (bit_cnt == DATA_BITS)) begin
                    state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                cnt_en      = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = edge_chk;
                if (edge_last) begin
                    state_nxt = par_err ? IDLE : STOP;
                end
            end
            STOP: begin
                cnt_en      = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = edge_chk;
                if (edge_last) begin
                    state_nxt      = IDLE;
                    data_valid_nxt = !stp_err;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef RX_FSM_FRAME_ERR_EN
    logic frm_set;

    // Set on a failed parity or stop check; a later good frame clears it.
    assign frm_set = edge_last &&
                     (((state == STOP) && stp_err) || ((state == PARITY) && par_err));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_err <= 1'b0;
        end else if (frm_set) begin
            frm_err <= 1'b1;
        end else if (data_valid) begin
            frm_err <= 1'b0;
        end
    end
`else
    assign frm_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: frame-level bench for uart_rx_fsm at PRESCALE 8, 16 and 32,
// each instance driven by a behavioural edge/bit counter.
module tb_uart_rx_fsm;

    localparam int NI = 3;

`ifdef RX_FSM_FRAME_ERR_EN
    localparam bit FRM_ON = 1'b1;
`else
    localparam bit FRM_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NI-1:0] rx_v;
    logic          par_en, strt_glitch, par_err, stp_err;
    logic [NI-1:0] cnt_en_v, samp_v, deser_v, strt_v, par_v, stp_v, dv_v, frm_v;
    logic [5:0]    edge_v [NI];
    logic [3:0]    bit_v  [NI];

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int P = 8 << g;
        logic [5:0] ec;
        logic [3:0] bc;

        // Counter: 0 after a cycle with cnt_en low, else 1..P, counting whole bits.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ec <= '0;
                bc <= '0;
            end else if (!cnt_en_v[g]) begin
                ec <= '0;
                bc <= '0;
            end else if (ec == 6'(P)) begin
                ec <= 6'd1;
                bc <= bc + 4'd1;
            end else begin
                ec <= ec + 6'd1;
            end
        end

        assign edge_v[g] = ec;
        assign bit_v[g]  = bc;

        uart_rx_fsm #(.PRESCALE(P)) dut (
            .clk         (clk),
            .rst         (rst),
            .rx_in       (rx_v[g]),
            .par_en      (par_en),
            .edge_cnt    (ec),
            .bit_cnt     (bc),
            .strt_glitch (strt_glitch),
            .par_err     (par_err),
            .stp_err     (stp_err),
            .cnt_en      (cnt_en_v[g]),
            .dat_samp_en (samp_v[g]),
            .deser_en    (deser_v[g]),
            .strt_chk_en (strt_v[g]),
            .par_chk_en  (par_v[g]),
            .stp_chk_en  (stp_v[g]),
            .data_valid  (dv_v[g]),
            .frm_err     (frm_v[g])
        );
    end

    typedef enum int {EV_STRT, EV_DESER, EV_PAR, EV_STP, EV_DV} ev_t;
    typedef struct { ev_t ev; int ec; bit after_e; } obs_t;

    ev_t  sb_q [$];
    obs_t obs_q [$];
    bit   sb_on  = 1'b0;
    int   act    = 0;
    bit   prev_e = 1'b0;
    int   total  = 0;
    int   bad    = 0;

    // Strobe monitor: records what the active instance emits; prev_e marks a STOP E-cycle.
    always @(negedge clk) begin
        if (sb_on) begin
            if (strt_v[act])  obs_q.push_back('{EV_STRT,  int'(edge_v[act]), prev_e});
            if (deser_v[act]) obs_q.push_back('{EV_DESER, int'(edge_v[act]), prev_e});
            if (par_v[act])   obs_q.push_back('{EV_PAR,   int'(edge_v[act]), prev_e});
            if (stp_v[act])   obs_q.push_back('{EV_STP,   int'(edge_v[act]), prev_e});
            if (dv_v[act])    obs_q.push_back('{EV_DV,    int'(edge_v[act]), prev_e});
        end
        prev_e = cnt_en_v[act] && (edge_v[act] == 6'(8 << act)) && (bit_v[act] >= 4'd9);
    end

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cnt(input int g, input logic lvl, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (cnt_en_v[g] == lvl) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    // Serial line: start bit, nbits data LSB-first, optional parity, then idle high.
    task automatic drive_bits(input int g, input logic [7:0] d, input bit pe,
                              input bit pe_flip, input int nbits);
        int p;
        p = 8 << g;
        rx_v[g] = 1'b0;
        tick(p);
        if (pe_flip) par_en = ~par_en;
        for (int i = 0; i < nbits; i++) begin
            rx_v[g] = d[i];
            tick(p);
        end
        if (pe) begin
            rx_v[g] = ^d;
            tick(p);
        end
        rx_v[g] = 1'b1;
    endtask

    task automatic push_frame(input int n_deser, input bit ep, input bit es, input bit edv);
        sb_q.push_back(EV_STRT);
        for (int i = 0; i < n_deser; i++) sb_q.push_back(EV_DESER);
        if (ep)  sb_q.push_back(EV_PAR);
        if (es)  sb_q.push_back(EV_STP);
        if (edv) sb_q.push_back(EV_DV);
    endtask

    task automatic drain();
        obs_t o;
        ev_t  e;
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check("strobe expected", (sb_q.size() > 0) ? 1 : 0, 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("strobe kind", int'(o.ev), int'(e));
                if (o.ev == EV_DV) check("dv after stop edge", int'(o.after_e), 1);
                else               check("strobe edge", o.ec, (8 << act) - 1);
            end
        end
        check("strobes missing", sb_q.size(), 0);
        sb_q.delete();
    endtask

    typedef struct {
        int         g;
        logic [7:0] data;
        bit         pe, pe_flip, glitch, perr, serr;
        int         n_deser;
        bit         exp_par, exp_stp, exp_dv, exp_frm;
    } vec_t;

    vec_t vecs [9];

    initial begin
        bit ok;
        int dv_seen;

        vecs[0] = '{0, 8'hA5, 0, 0, 0, 0, 0, 8, 0, 1, 1, 0};
        vecs[1] = '{0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[2] = '{0, 8'h3C, 1, 0, 0, 1, 0, 8, 1, 0, 0, 1};
        vecs[3] = '{0, 8'h81, 1, 0, 0, 0, 0, 8, 1, 1, 1, 0};
        vecs[4] = '{0, 8'h7E, 0, 1, 0, 0, 0, 8, 0, 1, 1, 0};
        vecs[5] = '{0, 8'h42, 1, 1, 0, 0, 0, 8, 1, 1, 1, 0};
        vecs[6] = '{1, 8'hA5, 0, 0, 0, 0, 0, 8, 0, 1, 1, 0};
        vecs[7] = '{2, 8'hA5, 0, 0, 0, 0, 0, 8, 0, 1, 1, 0};
        vecs[8] = '{0, 8'hFF, 0, 0, 0, 0, 1, 8, 0, 1, 0, 1};

        rst = 1'b1;
        rx_v = '1;
        par_en = 1'b0;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
        tick(2);
        check("reset outputs", int'({cnt_en_v, samp_v, deser_v, strt_v, par_v, stp_v, dv_v, frm_v}), 0);
        rst = 1'b0;
        tick(2);
        check("idle after reset", int'(cnt_en_v), 0);

        foreach (vecs[k]) begin
            act         = vecs[k].g;
            par_en      = vecs[k].pe;
            strt_glitch = vecs[k].glitch;
            par_err     = vecs[k].perr;
            stp_err     = vecs[k].serr;
            push_frame(vecs[k].n_deser, vecs[k].exp_par, vecs[k].exp_stp, vecs[k].exp_dv);
            sb_on = 1'b1;
            if (vecs[k].glitch) begin
                rx_v[act] = 1'b0;
                tick(3);
                rx_v[act] = 1'b1;
            end else begin
                drive_bits(act, vecs[k].data, vecs[k].pe, vecs[k].pe_flip, 8);
            end
            wait_cnt(act, 1'b0, 40 * (8 << act), ok);
            check("frame returns to idle", int'(ok), 1);
            tick(3);
            sb_on = 1'b0;
            drain();
            check("frm_err after frame", int'(frm_v[act]), int'(vecs[k].exp_frm & FRM_ON));
        end

        // Stop error followed by a clean frame with a single IDLE cycle between them.
        act = 0;
        par_en = 1'b0;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b1;
        push_frame(8, 0, 1, 0);
        push_frame(8, 0, 1, 1);
        sb_on = 1'b1;
        drive_bits(0, 8'h5A, 0, 0, 8);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cnt_en_v[0] && edge_v[0] == 6'd8 && bit_v[0] == 4'd9) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check("stop edge reached", int'(ok), 1);
        tick(1);
        check("single idle cycle", int'(cnt_en_v[0]), 0);
        check("frm_err set by stop error", int'(frm_v[0]), int'(FRM_ON));
        rx_v[0] = 1'b0;
        stp_err = 1'b0;
        tick(1);
        check("back-to-back start", int'(cnt_en_v[0]), 1);
        drive_bits(0, 8'hC3, 0, 0, 8);
        wait_cnt(0, 1'b0, 320, ok);
        check("second frame ends", int'(ok), 1);
        tick(3);
        sb_on = 1'b0;
        drain();
        check("frm_err cleared by data_valid", int'(frm_v[0]), 0);

        // Reset in the middle of DATA.
        rx_v[0] = 1'b0;
        tick(24);
        check("mid-frame busy", int'(cnt_en_v[0]), 1);
        rst = 1'b1;
        #1;
        check("async reset outputs", int'({cnt_en_v[0], samp_v[0], deser_v[0], strt_v[0],
                                           par_v[0], stp_v[0], dv_v[0], frm_v[0]}), 0);
        rx_v[0] = 1'b1;
        tick(2);
        rst = 1'b0;
        dv_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            dv_seen += int'(dv_v[0]) + int'(cnt_en_v[0]);
        end
        check("idle and silent after reset", dv_seen, 0);

        // Line stuck low with stop errors: restart right after each IDLE cycle.
        stp_err = 1'b1;
        rx_v[0] = 1'b0;
        dv_seen = 0;
        for (int f = 0; f < 2; f++) begin
            wait_cnt(0, 1'b1, 10, ok);
            check("held-low frame starts", int'(ok), 1);
            wait_cnt(0, 1'b0, 200, ok);
            check("held-low frame ends", int'(ok), 1);
            dv_seen += int'(dv_v[0]);
            tick(1);
            check("held-low restart", int'(cnt_en_v[0]), 1);
        end
        rx_v[0] = 1'b1;
        wait_cnt(0, 1'b0, 200, ok);
        dv_seen += int'(dv_v[0]);
        tick(1);
        dv_seen += int'(dv_v[0]);
        check("no data_valid with stop errors", dv_seen, 0);
        check("idle after line release", int'(ok), 1);
        stp_err = 1'b0;
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
